// File: rtl/rotate_pkg.sv
// Shared definitions for the tiled image-rotation address generator:
// sequencer states, rotation constants and the effective-rotation helper.
package rotate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [1:0] DEG_0   = 2'd0;
  localparam logic [1:0] DEG_90  = 2'd1;
  localparam logic [1:0] DEG_180 = 2'd2;
  localparam logic [1:0] DEG_270 = 2'd3;

  // Counter-clockwise by d quarter turns equals clockwise by (4 - d) mod 4.
  function automatic logic [1:0] effective_rot(input logic direction, input logic [1:0] degrees);
    return direction ? degrees : (2'd0 - degrees);
  endfunction

endpackage

// File: rtl/rotate_coord_map.sv
// Maps a source pixel (y, x) to its rotated destination coordinates and the
// destination row pitch in pixels. Purely combinational.
module rotate_coord_map
  import rotate_pkg::*;
#(
  parameter int DIM_W = 16
) (
  input  logic [DIM_W-1:0] y,
  input  logic [DIM_W-1:0] x,
  input  logic [DIM_W-1:0] h,
  input  logic [DIM_W-1:0] w,
  input  logic [1:0]       rot,
  output logic [DIM_W-1:0] dy,
  output logic [DIM_W-1:0] dx,
  output logic [DIM_W-1:0] dw
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    dy = y;
    dx = x;
    dw = w;
    case (rot)
      DEG_90: begin
        dy = x;
        dx = h - DIM_W'(1) - y;
        dw = h;
      end
      DEG_180: begin
        dy = h - DIM_W'(1) - y;
        dx = w - DIM_W'(1) - x;
        dw = w;
      end
      DEG_270: begin
        dy = w - DIM_W'(1) - x;
        dx = y;
        dw = h;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rotate_addr_gen.sv
// Tile-based read/write address sequencer for image rotation: per TxT tile it
// issues T*T source reads then T*T rotated destination writes, flagging padding.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int TILE_LOG2 = 3,
  parameter int BPP       = 3,
  parameter int DIM_W     = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                   I_HCLK,
  input  logic                   I_HRESET,
  input  logic                   I_START,
  input  logic [DIM_W-1:0]       I_HEIGHT,
  input  logic [DIM_W-1:0]       I_WIDTH,
  input  logic                   I_DIRECTION,
  input  logic [1:0]             I_DEGREES,
  input  logic [ADDR_W-1:0]      I_SRC_BASE,
  input  logic [ADDR_W-1:0]      I_DST_BASE,
  input  logic                   I_DMA_READY,
  output logic [ADDR_W-1:0]      O_ADDR,
  output logic                   O_VALID,
  output logic                   O_WRITE,
  output logic                   O_PAD,
  output logic [2*TILE_LOG2-1:0] O_COUNT,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic                   O_ERROR
);

  localparam int T      = 1 << TILE_LOG2;
  localparam int CNT_W  = 2 * TILE_LOG2;
  localparam int PROD_W = 2 * DIM_W + $clog2(BPP) + 1;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    h_q, w_q, ht_last_q, wt_last_q, tx_q, ty_q;
  logic [DIM_W-1:0]    ht_last_d, wt_last_d;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [1:0]          rot_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                error_q;

  logic start_bad, start_ok, active, accept, beat_last, tile_last;

  assign start_bad = (I_HEIGHT == '0) || (I_WIDTH == '0) || I_HEIGHT[DIM_W-1] || I_WIDTH[DIM_W-1];
  assign start_ok  = (state_q == IDLE) && I_START && !start_bad;
  assign active    = (state_q == READ) || (state_q == WRITE);
  assign accept    = active && I_DMA_READY;
  assign beat_last = (cnt_q == '1);
  assign tile_last = (ty_q == ht_last_q) && (tx_q == wt_last_q);

  // Dimensions are below 2**(DIM_W-1), so rounding up to a tile cannot overflow.
  assign ht_last_d = ((I_HEIGHT + DIM_W'(T - 1)) >> TILE_LOG2) - DIM_W'(1);
  assign wt_last_d = ((I_WIDTH + DIM_W'(T - 1)) >> TILE_LOG2) - DIM_W'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = READ;
      READ:    if (accept && beat_last) state_d = WRITE;
      WRITE:   if (accept && beat_last) state_d = tile_last ? FIN : READ;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      h_q       <= '0;
      w_q       <= '0;
      ht_last_q <= '0;
      wt_last_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rot_q     <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= (state_q == IDLE) && I_START && start_bad;
      if (start_ok) begin
        h_q       <= I_HEIGHT;
        w_q       <= I_WIDTH;
        ht_last_q <= ht_last_d;
        wt_last_q <= wt_last_d;
        src_q     <= I_SRC_BASE;
        dst_q     <= I_DST_BASE;
        rot_q     <= effective_rot(I_DIRECTION, I_DEGREES);
        tx_q      <= '0;
        ty_q      <= '0;
        cnt_q     <= '0;
      end else if (accept) begin
        // The beat counter wraps to 0 after the last beat of each phase.
        cnt_q <= cnt_q + CNT_W'(1);
        if ((state_q == WRITE) && beat_last) begin
          if (ty_q == ht_last_q) begin
            ty_q <= '0;
            tx_q <= tx_q + DIM_W'(1);
          end else begin
            ty_q <= ty_q + DIM_W'(1);
          end
        end
      end
    end
  end

  logic [TILE_LOG2-1:0] row, col;
  logic [DIM_W-1:0]     y, x, dy, dx, dw, sel_y, sel_x, sel_w;
  logic [ADDR_W-1:0]    sel_base, addr_raw;
  logic [PROD_W-1:0]    lin, offset;
  logic                 pad;

  assign row = cnt_q[CNT_W-1:TILE_LOG2];
  assign col = cnt_q[TILE_LOG2-1:0];
  assign y   = (ty_q << TILE_LOG2) | DIM_W'(row);
  assign x   = (tx_q << TILE_LOG2) | DIM_W'(col);
  assign pad = (y >= h_q) || (x >= w_q);

  rotate_coord_map #(.DIM_W(DIM_W)) u_coord_map (
    .y   (y),
    .x   (x),
    .h   (h_q),
    .w   (w_q),
    .rot (rot_q),
    .dy  (dy),
    .dx  (dx),
    .dw  (dw)
  );

  always_comb begin
    if (state_q == WRITE) begin
      sel_y = dy;  sel_x = dx;  sel_w = dw;  sel_base = dst_q;
    end else begin
      sel_y = y;   sel_x = x;   sel_w = w_q; sel_base = src_q;
    end
  end

  assign lin      = PROD_W'(sel_y) * PROD_W'(sel_w) + PROD_W'(sel_x);
  assign offset   = lin * PROD_W'(BPP);
  assign addr_raw = sel_base + ADDR_W'(offset);

  assign O_VALID = active;
  assign O_WRITE = (state_q == WRITE);
  assign O_PAD   = active && pad;
  assign O_ADDR  = active ? addr_raw : '0;
  assign O_COUNT = cnt_q;
  assign O_BUSY  = (state_q != IDLE);
  assign O_DONE  = (state_q == FIN);
  assign O_ERROR = error_q;

endmodule

// File: tb/tb_rotate_addr_gen.sv
// Self-checking bench for rotate_addr_gen: directed and randomized operations
// compared beat-by-beat against a coordinate-level reference model.
module tb_rotate_addr_gen;

  localparam int T   = 8;
  localparam int BPP = 3;

  logic        I_HCLK = 1'b0;
  logic        I_HRESET, I_START, I_DIRECTION, I_DMA_READY;
  logic [15:0] I_HEIGHT, I_WIDTH;
  logic [1:0]  I_DEGREES;
  logic [31:0] I_SRC_BASE, I_DST_BASE;
  logic [31:0] O_ADDR;
  logic        O_VALID, O_WRITE, O_PAD, O_BUSY, O_DONE, O_ERROR;
  logic [5:0]  O_COUNT;

  always #5 I_HCLK = ~I_HCLK;

  rotate_addr_gen dut (
    .I_HCLK(I_HCLK), .I_HRESET(I_HRESET), .I_START(I_START),
    .I_HEIGHT(I_HEIGHT), .I_WIDTH(I_WIDTH), .I_DIRECTION(I_DIRECTION),
    .I_DEGREES(I_DEGREES), .I_SRC_BASE(I_SRC_BASE), .I_DST_BASE(I_DST_BASE),
    .I_DMA_READY(I_DMA_READY), .O_ADDR(O_ADDR), .O_VALID(O_VALID),
    .O_WRITE(O_WRITE), .O_PAD(O_PAD), .O_COUNT(O_COUNT), .O_BUSY(O_BUSY),
    .O_DONE(O_DONE), .O_ERROR(O_ERROR)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          pad;
    logic [31:0] addr;
    int          cnt;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] acc_addr[$];
  bit          acc_pad[$];
  int          done_cnt;

  // Reference: enumerate tiles/phases/beats and place each pixel by rotation geometry.
  task automatic build_model(input int h, input int w, input bit dir, input int deg,
                             input logic [31:0] src, input logic [31:0] dst);
    int rot = dir ? deg : (4 - deg) % 4;
    int ht  = (h + T - 1) / T;
    int wt  = (w + T - 1) / T;
    exp_q.delete();
    for (int tx = 0; tx < wt; tx++)
      for (int ty = 0; ty < ht; ty++)
        for (int ph = 0; ph < 2; ph++)
          for (int k = 0; k < T * T; k++) begin
            beat_t  b;
            longint y, x, dy, dx, dw;
            y = ty * T + k / T;
            x = tx * T + k % T;
            case (rot)
              0:       begin dy = y;         dx = x;         dw = w; end
              1:       begin dy = x;         dx = h - 1 - y; dw = h; end
              2:       begin dy = h - 1 - y; dx = w - 1 - x; dw = w; end
              default: begin dy = w - 1 - x; dx = y;         dw = h; end
            endcase
            b.wr   = (ph == 1);
            b.pad  = (y >= h) || (x >= w);
            b.cnt  = k;
            b.addr = ph ? 32'(longint'(dst) + (dy * dw + dx) * BPP)
                        : 32'(longint'(src) + (y * w + x) * BPP);
            exp_q.push_back(b);
          end
  endtask

  // mode 0: ready always high, 1: repeating 1,0,0,1, 2: random (~75% high)
  task automatic run_op(input int h, input int w, input bit dir, input logic [1:0] deg,
                        input logic [31:0] src, input logic [31:0] dst,
                        input int mode, input string tag);
    int          budget, cyc, total;
    bit          seen_done, stalled;
    logic [31:0] prev_addr;
    logic [5:0]  prev_cnt;
    build_model(h, w, dir, int'(deg), src, dst);
    total = exp_q.size();
    acc_addr.delete();
    acc_pad.delete();
    done_cnt = 0;
    I_HEIGHT = 16'(h); I_WIDTH = 16'(w); I_DIRECTION = dir; I_DEGREES = deg;
    I_SRC_BASE = src; I_DST_BASE = dst; I_DMA_READY = 1'b0;
    @(negedge I_HCLK) I_START = 1'b1;
    @(negedge I_HCLK) I_START = 1'b0;
    budget = 4 * total + 50;
    cyc = 0; seen_done = 0; stalled = 0; prev_addr = '0; prev_cnt = '0;
    while (!seen_done && cyc < budget) begin
      case (mode)
        0:       I_DMA_READY = 1'b1;
        1:       I_DMA_READY = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: I_DMA_READY = ($urandom_range(0, 3) != 0);
      endcase
      if (O_DONE) begin
        done_cnt++;
        seen_done = 1;
      end else if (O_VALID) begin
        if (stalled) begin
          check({tag, "_hold_addr"}, O_ADDR, prev_addr);
          check({tag, "_hold_count"}, O_COUNT, prev_cnt);
        end
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, O_VALID, 1'b0);
        end else begin
          beat_t e = exp_q[0];
          check({tag, "_write"}, O_WRITE, e.wr);
          check({tag, "_pad"}, O_PAD, e.pad);
          check({tag, "_count"}, O_COUNT, 64'(e.cnt));
          if (!e.pad) check({tag, "_addr"}, O_ADDR, e.addr);
          if (I_DMA_READY) begin
            void'(exp_q.pop_front());
            acc_addr.push_back(O_ADDR);
            acc_pad.push_back(O_PAD);
          end
        end
        stalled   = !I_DMA_READY;
        prev_addr = O_ADDR;
        prev_cnt  = O_COUNT;
      end
      @(negedge I_HCLK);
      cyc++;
    end
    I_DMA_READY = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1'b1);
    check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_beats_acc"}, 64'(acc_addr.size()), 64'(total));
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_pulse"}, O_DONE, 1'b0);
    check({tag, "_idle_busy"}, O_BUSY, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  O_ADDR,  32'd0);
    check({tag, "_valid"}, O_VALID, 1'b0);
    check({tag, "_write"}, O_WRITE, 1'b0);
    check({tag, "_pad"},   O_PAD,   1'b0);
    check({tag, "_count"}, O_COUNT, 6'd0);
    check({tag, "_busy"},  O_BUSY,  1'b0);
    check({tag, "_done"},  O_DONE,  1'b0);
    check({tag, "_error"}, O_ERROR, 1'b0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ref_wr[$];
    int          pads, wi, dones, waited;

    I_HRESET = 1'b1; I_START = 1'b0; I_DMA_READY = 1'b0;
    I_HEIGHT = '0; I_WIDTH = '0; I_DIRECTION = 1'b0; I_DEGREES = '0;
    I_SRC_BASE = '0; I_DST_BASE = '0;
    repeat (3) @(negedge I_HCLK);
    I_HRESET = 1'b0;
    @(negedge I_HCLK);
    check_all_zero("reset");

    // 8x8 at 0 degrees, ready always high
    run_op(8, 8, 1'b1, 2'd0, 32'h0, 32'h1000, 0, "deg0");
    check("deg0_rd0", acc_addr[0], 32'h0);
    check("deg0_rd8", acc_addr[8], 32'h18);
    check("deg0_wr0", acc_addr[64], 32'h1000);

    // 8x8 clockwise 90
    run_op(8, 8, 1'b1, 2'd1, 32'h0, 32'h1000, 0, "cw90");
    check("cw90_wr0", acc_addr[64], 32'h1015);
    check("cw90_wr1", acc_addr[65], 32'h102D);
    pads = 0;
    foreach (acc_pad[i]) pads += int'(acc_pad[i]);
    check("cw90_no_pad", 64'(pads), 64'd0);

    // 16x8: counter-clockwise 90 must write exactly where clockwise 270 writes
    run_op(16, 8, 1'b1, 2'd3, 32'h40, 32'h2000, 2, "cw270");
    ref_wr.delete();
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < 64; k++) ref_wr.push_back(acc_addr[t * 128 + 64 + k]);
    run_op(16, 8, 1'b0, 2'd1, 32'h40, 32'h2000, 2, "ccw90");
    wi = 0;
    for (int t = 0; t < 2; t++)
      for (int k = 0; k < 64; k++) begin
        check("ccw90_vs_cw270", acc_addr[t * 128 + 64 + k], ref_wr[wi]);
        wi++;
      end

    // 10x10: four tiles with padding; second tile is (ty=1, tx=0)
    run_op(10, 10, 1'b1, 2'd0, 32'h100, 32'h8000, 0, "pad10");
    check("pad10_t1_b0", acc_pad[128], 1'b0);
    check("pad10_t1_b16", acc_pad[144], 1'b1);

    // Stall pattern 1,0,0,1 with 180 degrees and padding
    run_op(9, 12, 1'b0, 2'd2, 32'h10, 32'h4000, 1, "stall");

    // Randomized geometry, rotation and ready
    for (int n = 0; n < 4; n++)
      run_op(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, 2, "rand");

    // Rejected starts: zero height, then width with top bit set
    I_HEIGHT = 16'd0; I_WIDTH = 16'd8;
    @(negedge I_HCLK) I_START = 1'b1;
    @(negedge I_HCLK) I_START = 1'b0;
    check("err_h0_pulse", O_ERROR, 1'b1);
    check("err_h0_busy", O_BUSY, 1'b0);
    @(negedge I_HCLK);
    check("err_h0_one_cycle", O_ERROR, 1'b0);
    check("err_h0_still_idle", O_BUSY, 1'b0);
    I_HEIGHT = 16'd8; I_WIDTH = 16'h8000;
    @(negedge I_HCLK) I_START = 1'b1;
    @(negedge I_HCLK) I_START = 1'b0;
    check("err_wmsb_pulse", O_ERROR, 1'b1);
    check("err_wmsb_busy", O_BUSY, 1'b0);

    // Reset during the write phase aborts without a done pulse
    I_HEIGHT = 16'd8; I_WIDTH = 16'd8; I_DIRECTION = 1'b1; I_DEGREES = 2'd0;
    I_DMA_READY = 1'b1;
    @(negedge I_HCLK) I_START = 1'b1;
    @(negedge I_HCLK) I_START = 1'b0;
    waited = 0;
    while (!O_WRITE && waited < 200) begin
      @(negedge I_HCLK);
      waited++;
    end
    check("rst_reached_write", O_WRITE, 1'b1);
    repeat (3) @(negedge I_HCLK);
    I_HRESET = 1'b1;
    @(negedge I_HCLK);
    check_all_zero("rst_mid");
    I_HRESET = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge I_HCLK);
      dones += int'(O_DONE);
    end
    check("rst_no_done", 64'(dones), 64'd0);
    check("rst_idle", O_BUSY, 1'b0);
    I_DMA_READY = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotate_addr_gen.md
Name: rotate_addr_gen

Overview:
Parametrised tile-based address generator for the image-rotation datapath; successor to the fixed 8x8 / 3-byte read-write sequencer.
Walks the source image in TxT pixel tiles. For each tile it issues T*T read addresses, then T*T write addresses rotated by 0/90/180/270 degrees in either direction.
Sits between the register block (geometry, bases, start) and the DMA master (per-beat ready handshake). Padding beats are flagged so the DMA can skip them.

Parameters:
TILE_LOG2, 3, log2 of tile edge T (T = 2**TILE_LOG2)
BPP, 3, bytes per pixel
DIM_W, 16, width of height/width inputs
ADDR_W, 32, address width

Ports:
I_HCLK  in  1  clock
I_HRESET  in  1  synchronous active-high reset
I_START  in  1  start request, sampled in IDLE only
I_HEIGHT  in  DIM_W  source height H in pixels
I_WIDTH  in  DIM_W  source width W in pixels
I_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise
I_DEGREES  in  2  0/1/2/3 = 0/90/180/270 degrees
I_SRC_BASE  in  ADDR_W  source byte base address
I_DST_BASE  in  ADDR_W  destination byte base address
I_DMA_READY  in  1  DMA accepts the current beat
O_ADDR  out  ADDR_W  byte address of the current beat
O_VALID  out  1  beat presented
O_WRITE  out  1  0 = read beat, 1 = write beat
O_PAD  out  1  beat is outside the image; DMA does no transfer
O_COUNT  out  2*TILE_LOG2  beat index within the tile
O_BUSY  out  1  operation in progress
O_DONE  out  1  one-cycle completion pulse
O_ERROR  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation aborts immediately; no DONE pulse.
- States: IDLE, READ, WRITE, FIN.
- IDLE with I_START=1:
  - If H=0, W=0, H[DIM_W-1]=1 or W[DIM_W-1]=1: O_ERROR=1 for one cycle; stay in IDLE.
  - Otherwise latch H, W, bases and effective rotation R; go to READ next cycle.
  - R = I_DEGREES when I_DIRECTION=1, else (4 - I_DEGREES) mod 4.
  - Inputs are not sampled again until the next IDLE. I_START outside IDLE is ignored.
- Padded dimensions: Hp and Wp are H and W rounded up to a multiple of T. Tile counts: HT = Hp/T, WT = Wp/T.
- Tile order: tile column tx is the outer loop, tile row ty is the inner loop (ty runs 0..HT-1 for each tx).
- Beat k in 0..T*T-1 maps to r = k / T, c = k mod T; y = ty*T + r, x = tx*T + c.
- O_VALID=1 in READ and WRITE. A beat is accepted when O_VALID and I_DMA_READY are both 1.
- Counters advance only on acceptance. O_ADDR, O_PAD and O_COUNT hold stable while I_DMA_READY=0.
- No combinational path from I_DMA_READY to any output.
- READ beat address: SRC_BASE + (y*W + x)*BPP.
- WRITE phase uses the same beat order as READ. Destination coordinates (dy, dx) and destination width DW:
  - R=0: (y, x), DW=W
  - R=1: (x, H-1-y), DW=H
  - R=2: (H-1-y, W-1-x), DW=W
  - R=3: (W-1-x, y), DW=H
- WRITE beat address: DST_BASE + (dy*DW + dx)*BPP.
- O_PAD = (y >= H) or (x >= W), identical in both phases. O_ADDR is don't-care when O_PAD=1 and is still counted as a beat.
- Phase transitions:
  - Acceptance of beat T*T-1 in READ goes to WRITE.
  - Acceptance of beat T*T-1 in WRITE goes to READ of the next tile, or to FIN after the last tile.
  - FIN: O_DONE=1 for one cycle, then IDLE.
- O_BUSY is 1 in READ, WRITE and FIN.
- Arithmetic: address sums are truncated modulo 2**ADDR_W. Intermediate products must be at least 2*DIM_W + log2(BPP)+1 bits wide.
- O_ADDR may be combinational from registered counters and latched config.

Decomposition:
- Package rotate_pkg: state encoding (IDLE/READ/WRITE/FIN), degree constants DEG_0..DEG_270, and the effective-rotation function. The existing core_set constants migrate here.
- One sub-module, rotate_coord_map: combinational; takes (y, x, H, W, R) and returns (dy, dx, DW).

Test Plan:
- 8x8, BPP=3, SRC_BASE=0, DST_BASE=0x1000, 0 degrees, READY=1 -> read beat 0 = 0x0, read beat 8 = 0x18; write beat 0 = 0x1000; 128 accepted beats, then O_DONE.
- 8x8, clockwise 90, same bases -> write beat 0 = 0x1015, write beat 1 = 0x102D; no O_PAD.
- H=16, W=8, counter-clockwise 90 -> write addresses identical to clockwise 270; 256 accepted beats over 2 tiles; O_DONE asserted exactly once.
- H=10, W=10 -> 4 tiles; tile 2 (ty=1, tx=0): beat 0 has O_PAD=0, beat 16 has O_PAD=1; 512 beats total.
- READY toggled 1,0,0,1 -> O_ADDR and O_COUNT frozen during the low cycles; no beat skipped or duplicated.
- I_START with H=0 -> one-cycle O_ERROR, O_BUSY stays 0. Separately, I_HRESET asserted mid-WRITE -> all outputs 0 next cycle, no O_DONE.
